// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage. Issues one instruction-memory request at a time
//   from the current PC, writes the returned word into the IF/ID pipeline
//   register, and parks a word in a one-entry hold buffer when decode is
//   stalled in the same cycle that the word returns. A flush discards in-flight
//   work. A sticky flag reports a fetch that has waited TIMEOUT cycles.
//
// Parameters
//   NOP_INSTR     instruction word loaded into IF/ID on reset and on flush
//   TIMEOUT       wait-cycle limit (1..65535) that raises fetch_timeout
//
// Ports
//   clk           clock; all state changes on its rising edge
//   reset         asynchronous active-high reset
//   pc_current    current PC
//   pc_enable     load strobe for the program counter (combinational)
//   pc_plus4      pc_current + 4, wrapping modulo 2^32 (combinational)
//   imem_req      instruction-memory request (high in FETCH)
//   imem_addr     fetch address, always equal to pc_current
//   imem_ready    memory accepts the request and returns data this cycle
//   imem_rdata    instruction word, valid when imem_req && imem_ready
//   stall         decode cannot accept; IF/ID holds
//   flush         taken branch; discard in-flight work, reload the PC
//   ifid_*        IF/ID pipeline register (valid, instr, pc, pc_plus4)
//   fetch_timeout sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'hE1A00000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_current,
  output logic        pc_enable,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        fetch_timeout
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        accept_s;
  logic        imem_req_s;
  logic [31:0] hold_instr_r;
  logic [31:0] hold_pc_r;
  logic [31:0] hold_pc_plus4_r;
  logic [15:0] wait_cnt_r;
  logic [15:0] wait_next_s;
  logic        timeout_r;

  assign pc_plus4      = pc_current + 32'd4;
  assign imem_addr     = pc_current;
  assign imem_req      = imem_req_s;
  assign pc_enable     = flush | accept_s;
  assign fetch_timeout = timeout_r;

  // Next-state logic, memory request and acceptance decode
  always_comb begin
    state_next_s = FETCH;
    imem_req_s   = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      FETCH: begin
        imem_req_s = 1'b1;
        accept_s   = imem_ready;
        if (flush) begin
          state_next_s = FETCH;
        end else if (imem_ready && stall) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = FETCH;
        end
      end
      HOLD: begin
        if (flush) begin
          state_next_s = FETCH;
        end else if (stall) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = FETCH;
        end
      end
      default: begin
        state_next_s = FETCH;
      end
    endcase
  end

  // Wait counter next value: cleared whenever no fetch is outstanding,
  // saturating so a very long wait cannot wrap back below TIMEOUT
  always_comb begin
    wait_next_s = wait_cnt_r;
    if (flush || (state_r == HOLD) || accept_s) begin
      wait_next_s = 16'd0;
    end else if (wait_cnt_r != 16'hFFFF) begin
      wait_next_s = wait_cnt_r + 16'd1;
    end else begin
      wait_next_s = wait_cnt_r;
    end
  end

  // State register, IF/ID register and hold buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= FETCH;
      ifid_valid      <= 1'b0;
      ifid_instr      <= NOP_INSTR;
      ifid_pc         <= 32'd0;
      ifid_pc_plus4   <= 32'd0;
      hold_instr_r    <= 32'd0;
      hold_pc_r       <= 32'd0;
      hold_pc_plus4_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      if (flush) begin
        ifid_valid      <= 1'b0;
        ifid_instr      <= NOP_INSTR;
        ifid_pc         <= 32'd0;
        ifid_pc_plus4   <= 32'd0;
        hold_instr_r    <= 32'd0;
        hold_pc_r       <= 32'd0;
        hold_pc_plus4_r <= 32'd0;
      end else if (state_r == FETCH) begin
        if (imem_ready && !stall) begin
          ifid_valid    <= 1'b1;
          ifid_instr    <= imem_rdata;
          ifid_pc       <= pc_current;
          ifid_pc_plus4 <= pc_plus4;
        end else if (imem_ready) begin
          // Word returned while decode is stalled: park it until stall drops
          hold_instr_r    <= imem_rdata;
          hold_pc_r       <= pc_current;
          hold_pc_plus4_r <= pc_plus4;
        end else if (!stall) begin
          ifid_valid <= 1'b0;
        end
      end else if (!stall) begin
        ifid_valid    <= 1'b1;
        ifid_instr    <= hold_instr_r;
        ifid_pc       <= hold_pc_r;
        ifid_pc_plus4 <= hold_pc_plus4_r;
      end
    end
  end

  // Wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= 16'd0;
      timeout_r  <= 1'b0;
    end else begin
      wait_cnt_r <= wait_next_s;
      if (wait_next_s == TIMEOUT_W) begin
        timeout_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage (TIMEOUT overridden to 4). Stimulus pushes
//   the expected IF/ID contents of each instruction it expects to be loaded;
//   a monitor pops and compares whenever a new valid IF/ID entry appears.
//   Combinational outputs and control state are checked inline.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk;
  logic        reset;
  logic [31:0] pc_current;
  logic        pc_enable;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        fetch_timeout;

  int errors = 0;
  int checks = 0;
  logic [95:0] exp_q[$];

  fetch_stage #(.NOP_INSTR(NOP), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .pc_current(pc_current), .pc_enable(pc_enable),
    .pc_plus4(pc_plus4), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .flush(flush), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
    .fetch_timeout(fetch_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic rdy, input logic [31:0] rd,
                       input logic st, input logic fl);
    pc_current = pc;
    imem_ready = rdy;
    imem_rdata = rd;
    stall      = st;
    flush      = fl;
  endtask

  // Monitor: a new valid IF/ID entry is one that was invalid or different last sample
  initial begin
    logic        prev_valid;
    logic [95:0] prev_word;
    logic [95:0] cur;
    logic [95:0] exp;
    prev_valid = 1'b0;
    prev_word  = 96'd0;
    forever begin
      @(negedge clk);
      cur = {ifid_instr, ifid_pc, ifid_pc_plus4};
      if (ifid_valid === 1'b1 && (prev_valid !== 1'b1 || cur !== prev_word)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ifid_unexpected: got %h expected no load", cur);
        end else begin
          exp = exp_q.pop_front();
          if (cur !== exp) begin
            errors++;
            $display("FAIL ifid_entry: got %h expected %h", cur, exp);
          end
        end
      end
      prev_valid = ifid_valid;
      prev_word  = cur;
    end
  end

  initial begin
    reset = 1'b1;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, NOP);
    chk("rst_pc", ifid_pc, 32'd0);
    chk("rst_pc4", ifid_pc_plus4, 32'd0);
    chk("rst_timeout", {31'd0, fetch_timeout}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_pcen_idle", {31'd0, pc_enable}, 32'd0);
    imem_ready = 1'b1;
    #1;
    chk("rst_pcen_ready", {31'd0, pc_enable}, 32'd1);
    step();
    reset = 1'b0;

    // Sequential fetch
    drive(32'h100, 1'b1, 32'hE3A01005, 1'b0, 1'b0);
    @(negedge clk);
    chk("seq_pcen", {31'd0, pc_enable}, 32'd1);
    chk("seq_pc4", pc_plus4, 32'h104);
    chk("seq_addr", imem_addr, 32'h100);
    exp_q.push_back({32'hE3A01005, 32'h100, 32'h104});
    step();

    // Three wait states then a return
    drive(32'h200, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_pcen", {31'd0, pc_enable}, 32'd0);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      step();
      chk("wait_bubble", {31'd0, ifid_valid}, 32'd0);
    end
    drive(32'h200, 1'b1, 32'hE0811002, 1'b0, 1'b0);
    @(negedge clk);
    chk("wait_done_pcen", {31'd0, pc_enable}, 32'd1);
    exp_q.push_back({32'hE0811002, 32'h200, 32'h204});
    step();
    chk("wait_no_timeout", {31'd0, fetch_timeout}, 32'd0);

    // Stall on return: word parked in HOLD, released when stall drops
    drive(32'h300, 1'b1, 32'hE2822001, 1'b1, 1'b0);
    @(negedge clk);
    chk("stall_pcen", {31'd0, pc_enable}, 32'd1);
    step();
    drive(32'h304, 1'b1, 32'h11111111, 1'b1, 1'b0);
    @(negedge clk);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_pcen", {31'd0, pc_enable}, 32'd0);
    chk("hold_ifid_pc", ifid_pc, 32'h200);
    step();
    drive(32'h304, 1'b0, 32'h0, 1'b0, 1'b0);
    exp_q.push_back({32'hE2822001, 32'h300, 32'h304});
    step();
    chk("release_req", {31'd0, imem_req}, 32'd1);

    // Flush beats stall while in HOLD; parked word must be discarded
    drive(32'h400, 1'b1, 32'hE3A00001, 1'b1, 1'b0);
    step();
    drive(32'h404, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_pcen", {31'd0, pc_enable}, 32'd1);
    step();
    chk("flush_valid", {31'd0, ifid_valid}, 32'd0);
    chk("flush_instr", ifid_instr, NOP);
    chk("flush_pc", ifid_pc, 32'd0);
    chk("flush_req", {31'd0, imem_req}, 32'd1);
    drive(32'h500, 1'b1, 32'hE1A0F00E, 1'b0, 1'b0);
    exp_q.push_back({32'hE1A0F00E, 32'h500, 32'h504});
    step();

    // Flush in FETCH discards the word returned in the same cycle
    drive(32'h600, 1'b1, 32'h22222222, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_fetch_pcen", {31'd0, pc_enable}, 32'd1);
    step();
    chk("flush_fetch_valid", {31'd0, ifid_valid}, 32'd0);

    // PC wrap and timeout at 4 wait edges
    drive(32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("wrap_pc4", pc_plus4, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("timeout_flag", {31'd0, fetch_timeout}, (i == 4) ? 32'd1 : 32'd0);
    end
    drive(32'hFFFFFFFC, 1'b1, 32'hE12FFF1E, 1'b0, 1'b0);
    exp_q.push_back({32'hE12FFF1E, 32'hFFFFFFFC, 32'h0});
    step();
    step();
    chk("timeout_sticky", {31'd0, fetch_timeout}, 32'd1);

    // Reset mid-HOLD discards the parked word and clears the flag at once
    drive(32'h700, 1'b1, 32'h33333333, 1'b1, 1'b0);
    step();
    chk("pre_rst_hold_req", {31'd0, imem_req}, 32'd0);
    drive(32'h704, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_rst_timeout", {31'd0, fetch_timeout}, 32'd0);
    chk("async_rst_req", {31'd0, imem_req}, 32'd1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    step();
    step();
    chk("post_rst_valid", {31'd0, ifid_valid}, 32'd0);

    @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter NOP_INSTR, default 32'hE1A00000, SHALL be the instruction word loaded into IF/ID on reset and flush.
REQ-002 Parameter TIMEOUT, default 255, SHALL be the wait-cycle limit (1..65535) after which a pending fetch flags an error.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc_current  input  32  current PC from the program counter.
REQ-006 pc_enable  output  1  load strobe for the program counter.
REQ-007 pc_plus4  output  32  pc_current+4, sent to the next-PC mux.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  32  fetch address.
REQ-010 imem_ready  input  1  memory accepts the request and returns valid data this cycle.
REQ-011 imem_rdata  input  32  instruction word, valid only when imem_req&&imem_ready.
REQ-012 stall  input  1  decode cannot accept; IF/ID holds.
REQ-013 flush  input  1  branch taken; discard in-flight work and load the target into the PC.
REQ-014 ifid_valid / ifid_instr / ifid_pc / ifid_pc_plus4  output  1/32/32/32  IF/ID pipeline register.
REQ-015 fetch_timeout  output  1  sticky error flag.

Function
REQ-016 pc_plus4 SHALL be combinational pc_current+32'd4, wrapping modulo 2^32 (32'hFFFFFFFC -> 32'h0).
REQ-017 imem_addr SHALL equal pc_current combinationally at all times.
REQ-018 FSM states SHALL be FETCH and HOLD only.
REQ-019 FETCH: imem_req=1; HOLD: imem_req=0.
REQ-020 A fetch is accepted in a cycle when the state is FETCH and imem_ready=1.
REQ-021 pc_enable SHALL be combinational: 1 when flush=1 (any state), else 1 when a fetch is accepted, else 0.
REQ-022 Priority SHALL be reset > flush > stall.
REQ-023 flush=1: ifid_valid<=0, ifid_instr<=NOP_INSTR, ifid_pc/ifid_pc_plus4<=0, hold buffer invalidated, next state FETCH; any returned data that cycle is discarded.
REQ-024 FETCH, accepted, stall=0, flush=0: IF/ID <= {1, imem_rdata, pc_current, pc_plus4}; stay FETCH.
REQ-025 FETCH, accepted, stall=1, flush=0: {imem_rdata, pc_current, pc_plus4} captured into the hold buffer; IF/ID unchanged; next state HOLD.
REQ-026 FETCH, not accepted, stall=0, flush=0: ifid_valid<=0 (bubble); other IF/ID fields unchanged.
REQ-027 stall=1 with flush=0 SHALL keep all IF/ID fields unchanged.
REQ-028 HOLD, stall=0, flush=0: IF/ID <= {1, buffer}; next state FETCH.
REQ-029 HOLD, stall=1, flush=0: remain HOLD; buffer and IF/ID unchanged.
REQ-030 Latency: an instruction accepted in cycle N with stall=0 SHALL appear on IF/ID after edge N; at most one fetch in flight.
REQ-031 Wait counter (16-bit): cleared on acceptance, on flush, and in HOLD; it SHALL increment each FETCH cycle with imem_ready=0.
REQ-032 When the wait counter reaches TIMEOUT, fetch_timeout SHALL set and stay 1 until reset; fetching continues normally.

Reset
REQ-033 Asserting reset SHALL immediately (asynchronously) force state=FETCH, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus4=0, hold buffer cleared, wait counter=0, fetch_timeout=0.
REQ-034 While reset=1, pc_enable SHALL still follow REQ-021; the program counter's own reset overrides it.
REQ-035 Reset asserted mid-HOLD SHALL discard the held instruction; the first cycle after release SHALL be FETCH with imem_req=1.

Verification
REQ-036 Sequential fetch: pc_current=0x100, imem_ready=1, rdata=0xE3A01005 -> pc_enable=1; after edge ifid={1,0xE3A01005,0x100,0x104}.
REQ-037 Wait states: imem_ready low 3 cycles at pc=0x200 -> pc_enable=0 and ifid_valid=0 for 3 cycles; on 4th cycle ready -> IF/ID loads, pc_enable=1.
REQ-038 Stall on return: ready=1 and stall=1 at pc=0x300 -> IF/ID unchanged, pc_enable=1, state HOLD, imem_req=0 next cycle; stall drops -> ifid={1,word,0x300,0x304}.
REQ-039 Flush beats stall: HOLD with stall=1, flush=1 -> pc_enable=1; after edge ifid_valid=0, ifid_instr=0xE1A00000, state FETCH.
REQ-040 Wrap and timeout: pc=0xFFFFFFFC -> pc_plus4=0; TIMEOUT=4, ready held low -> fetch_timeout=1 after the 4th wait edge, stays 1 after ready returns, clears only on reset.
